oam_dma_controller: RTL
=======================

# oam_dma_controller

Sequences Game Boy OAM DMA: a CPU write to FF46 copies 160 bytes from `XX00`–`XX9F` into OAM at `FE00`–`FE9F`. It sits between the CPU and the mmu address/data port and takes over that port while a transfer runs. It holds the FF46 register, whose value the mmu reads back through its `iGPU_DMA` input. CPU access during a transfer is gated per the configuration below.

## Interface
- `WAIT_CLKS`, default 2: idle clocks after each byte's read and write cycles, so each byte takes 2+WAIT_CLKS clocks. Legal range 0–6.
- `iClock` in 1: single clock; all logic updates on its rising edge.
- `iReset` in 1: synchronous, active-low reset.
- `iCpuAddr` in 16: CPU address.
- `iCpuWe` in 1: CPU write strobe.
- `iCpuData` in 8: CPU write data.
- `iCpuReadRequest` in 1: CPU read strobe.
- `iMemData` in 8: mmu `oData`. It is valid the cycle after its address is presented, because the memories are synchronous.
- `oBusAddr` out 16: drives mmu `iCpuAddr`.
- `oBusWe` out 1: drives mmu `iCpuWe`.
- `oBusData` out 8: drives mmu `iCpuData`.
- `oBusReadRequest` out 1: drives mmu `iCpuReadRequest`.
- `oCpuData` out 8: read data returned to the CPU.
- `oCpuWait` out 1: CPU must hold its current access.
- `oDmaActive` out 1: high from the START state until the transfer completes.
- `oDmaReg` out 8: FF46 value, connected to mmu `iGPU_DMA`.

## Operation
States are IDLE, START, READ, WRITE and WAIT.

Register and trigger:
- A CPU write to FF46 with `iCpuWe`=1 loads `oDmaReg`, latches the source page and enters START.
- The source page is `iCpuData`. If it is ≥ 0xE0, the page is `iCpuData` − 0x20 (echo mirror). `oDmaReg` still holds the raw `iCpuData`.
- The FF46 write is also forwarded to the bus as a normal write.

State transitions:
- **START**: one clock. Byte index ← 0. Then go to READ.
- **READ**: `oBusAddr` = {page, index}, `oBusReadRequest` = 1, `oBusWe` = 0.
- **WRITE**: `oBusAddr` = 16'hFE00 + index, `oBusData` = `iMemData`, `oBusWe` = 1. Index increments by 1. If index was 159, go to IDLE; otherwise go to WAIT. If `WAIT_CLKS` = 0, go directly to READ instead of WAIT.
- **WAIT**: counts `WAIT_CLKS` clocks, then goes to READ. The bus is not used in this state.

Other rules:
- The index is 8 bits and compares to 159. It never wraps past 0x9F.
- Outside READ and WRITE, the bus outputs pass the CPU signals through unchanged, subject to the gating in Configuration.
- Restart: a CPU write to FF46 in any non-IDLE state reloads `oDmaReg` and the page and enters START on the next clock. The partial copy is abandoned.
- A DMA WRITE never targets FF46, so a trigger cannot collide with a DMA write.
- `oCpuData` = `iMemData` whenever the CPU owns the bus.

Reset values:
- State IDLE, index 0, `oDmaReg` 8'h00.
- `oDmaActive` 0, `oCpuWait` 0.
- Bus outputs pass through the CPU signals.
- A reset mid-transfer aborts it immediately. Bytes already written stay in OAM.

## Timing
- FF46 write accepted at edge t. START occupies cycle t+1. READ of byte 0 is cycle t+2. WRITE of byte 0 is cycle t+3.
- Byte n: READ at cycle t+2+n·(2+WAIT_CLKS), WRITE one cycle later.
- `oDmaActive` is high from cycle t+1 through the WRITE of byte 159, then low.
- Total active time: 1 + 160·(2+WAIT_CLKS) − WAIT_CLKS clocks. With the default this is 639.
- During DMA READ and WRITE cycles `oCpuWait` = 1 and the CPU access is not forwarded.
- The only path from CPU inputs to bus outputs is the passthrough mux. No input-to-output path crosses DMA-owned cycles.

## Configuration
Macro: `OAM_DMA_BUS_LOCK_EN`.

Defined (real hardware behaviour):
- While `oDmaActive` = 1, CPU accesses outside FF80–FFFE are blocked.
- Blocked reads return 8'hFF on `oCpuData` and are not forwarded.
- Blocked writes are dropped, except writes to FF46, which trigger a restart.
- `oCpuWait` stays 0 except in READ and WRITE cycles.
- CPU accesses to FF80–FFFE pass through in START and WAIT cycles and are held off by `oCpuWait` in READ and WRITE cycles.

Undefined:
- No address gating. CPU accesses anywhere pass through in START and WAIT cycles.
- CPU accesses are held off by `oCpuWait` only in READ and WRITE cycles.

## Structure
- Shared package constants:
  - `DMA_REG_ADDR` = 16'hFF46
  - `OAM_BASE` = 16'hFE00
  - `OAM_DMA_BYTES` = 160
  - `HRAM_LO` = 16'hFF80, `HRAM_HI` = 16'hFFFE
  - `ECHO_PAGE_MIN` = 8'hE0
  - state encoding enum
- No sub-module. The FSM, index counter and wait counter stay flat. The CPU/DMA bus mux is inline.

## Test plan
- **Reset:** hold reset low 3 clocks with CPU address FF46 and `iCpuWe` high → `oDmaReg`=00, `oDmaActive`=0, no transfer.
- **Full copy:** write C0 to FF46; model memory C000+i = i ^ 0x5A → FE00+i = i ^ 0x5A for i = 0..159; exactly 160 writes; `oDmaActive` high for 639 clocks; FE9F written last; `oDmaReg` = C0.
- **Echo source:** write E1 to FF46 → reads from C100–C19F; `oDmaReg` reads back E1.
- **Restart:** write C0, then write D0 after byte 40 → remaining writes resume at FE00 sourcing D000; 160 writes counted after the restart.
- **Bus lock (macro defined):** during DMA, a CPU read of 8000 returns FF; a CPU write to C000 is dropped; a CPU read of FF90 returns HRAM contents after the `oCpuWait` holds.
- **Reset mid-transfer:** assert reset at byte 80 → `oDmaActive` = 0 on the next clock; no further OAM writes; the CPU regains the bus.

Source files
------------

// File: rtl/oam_dma_controller_pkg.sv
// Shared constants, state encoding and source-page helper for the OAM DMA controller.
package oam_dma_controller_pkg;

   localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;
   localparam logic [15:0] OAM_BASE      = 16'hFE00;
   localparam int unsigned OAM_DMA_BYTES = 160;
   localparam logic [15:0] HRAM_LO       = 16'hFF80;
   localparam logic [15:0] HRAM_HI       = 16'hFFFE;
   localparam logic [7:0]  ECHO_PAGE_MIN = 8'hE0;
   localparam logic [7:0]  LAST_INDEX    = 8'(OAM_DMA_BYTES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StRead,
      StWrite,
      StWait
   } dma_state_e;

   // Pages E0..FF alias work RAM through the echo mirror.
   function automatic logic [7:0] src_page(input logic [7:0] val);
      return (val >= ECHO_PAGE_MIN) ? (val - 8'h20) : val;
   endfunction

endpackage

// File: rtl/oam_dma_controller.sv
// OAM DMA sequencer: owns the mmu port during READ/WRITE cycles, passes the CPU through otherwise.
// Optional CPU bus lock during a transfer is enabled by defining OAM_DMA_BUS_LOCK_EN.
module oam_dma_controller
   import oam_dma_controller_pkg::*;
#(
   parameter int unsigned WAIT_CLKS = 2
) (
   input  logic        iClock,
   input  logic        iReset,
   input  logic [15:0] iCpuAddr,
   input  logic        iCpuWe,
   input  logic [7:0]  iCpuData,
   input  logic        iCpuReadRequest,
   input  logic [7:0]  iMemData,
   output logic [15:0] oBusAddr,
   output logic        oBusWe,
   output logic [7:0]  oBusData,
   output logic        oBusReadRequest,
   output logic [7:0]  oCpuData,
   output logic        oCpuWait,
   output logic        oDmaActive,
   output logic [7:0]  oDmaReg
);

   localparam logic [2:0] WAIT_LAST = (WAIT_CLKS == 0) ? 3'd0 : 3'(WAIT_CLKS - 1);

   dma_state_e state_q, state_d;
   logic [7:0] index_q, index_d;
   logic [2:0] wait_q, wait_d;
   logic [7:0] dma_reg_q, dma_reg_d;
   logic [7:0] page_q, page_d;
   logic       trigger;

   assign trigger = iCpuWe && (iCpuAddr == DMA_REG_ADDR);

   always_ff @(posedge iClock) begin
      if (!iReset) begin
         state_q   <= StIdle;
         index_q   <= 8'h00;
         wait_q    <= 3'd0;
         dma_reg_q <= 8'h00;
         page_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         index_q   <= index_d;
         wait_q    <= wait_d;
         dma_reg_q <= dma_reg_d;
         page_q    <= page_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      index_d   = index_q;
      wait_d    = wait_q;
      dma_reg_d = dma_reg_q;
      page_d    = page_q;
      case (state_q)
         StStart: begin
            index_d = 8'h00;
            state_d = StRead;
         end
         StRead: state_d = StWrite;
         StWrite: begin
            if (index_q == LAST_INDEX) begin
               index_d = 8'h00;
               state_d = StIdle;
            end else begin
               index_d = index_q + 8'd1;
               wait_d  = 3'd0;
               state_d = (WAIT_CLKS == 0) ? StRead : StWait;
            end
         end
         StWait: begin
            if (wait_q == WAIT_LAST) state_d = StRead;
            else                     wait_d  = wait_q + 3'd1;
         end
         default: ;
      endcase
      // A new FF46 write wins over whatever the transfer was doing.
      if (trigger) begin
         dma_reg_d = iCpuData;
         page_d    = src_page(iCpuData);
         state_d   = StStart;
      end
   end

`ifdef OAM_DMA_BUS_LOCK_EN
   logic in_hram;
   assign in_hram = (iCpuAddr >= HRAM_LO) && (iCpuAddr <= HRAM_HI);
`endif

   always_comb begin
      oBusAddr        = iCpuAddr;
      oBusWe          = iCpuWe;
      oBusData        = iCpuData;
      oBusReadRequest = iCpuReadRequest;
      oCpuData        = iMemData;
      oCpuWait        = 1'b0;
      oDmaActive      = (state_q != StIdle);
`ifdef OAM_DMA_BUS_LOCK_EN
      // Outside HRAM only FF46 writes still reach the bus while a transfer runs.
      if (oDmaActive && !in_hram) begin
         oBusWe          = trigger;
         oBusReadRequest = 1'b0;
         oCpuData        = 8'hFF;
      end
`endif
      case (state_q)
         StRead: begin
            oBusAddr        = {page_q, index_q};
            oBusWe          = 1'b0;
            oBusReadRequest = 1'b1;
            oCpuWait        = 1'b1;
         end
         StWrite: begin
            oBusAddr        = OAM_BASE + {8'h00, index_q};
            oBusData        = iMemData;
            oBusWe          = 1'b1;
            oBusReadRequest = 1'b0;
            oCpuWait        = 1'b1;
         end
         default: ;
      endcase
   end

   assign oDmaReg = dma_reg_q;

endmodule
